// File: rtl/rr_arbiter_16_pkg.sv
// Shared constants and FSM encoding for the 16-way round-robin arbiter.
package rr_arbiter_16_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_16_dec.sv
// 4-to-16 one-hot decoder with an output enable; an all-zero output when disabled.
module dec_4_to_16 (
    input  logic [3:0]  addr,
    input  logic        en,
    output logic [15:0] dec
);

    always_comb begin
        dec = '0;
        if (en) begin
            dec[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with hold-time limit and one idle cycle between grants.
// Handshake: a requester holds req[i] high until granted; the grantee releases by pulsing done or dropping req[i].
module rr_arbiter_16
    import rr_arbiter_16_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic              done,
    output logic [N_REQ-1:0]  gnt,
    output logic [IDX_W-1:0]  gnt_id,
    output logic              gnt_vld,
    output logic              timeout,
    output arb_state_e        state_dbg
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_e       state;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       hold_cnt;

    logic             found;
    logic [IDX_W-1:0] found_id;
    logic [IDX_W-1:0] cand;
    logic             hold_expired;
    logic             release_now;

    // Walk downward so the smallest offset from ptr is the one left standing.
    always_comb begin
        found    = 1'b0;
        found_id = '0;
        cand     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                found    = 1'b1;
                found_id = cand;
            end
        end
    end

    assign hold_expired = (hold_cnt == HOLD_LAST);
    assign release_now  = done | ~req[gnt_id] | hold_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            gnt_id   <= '0;
            gnt_vld  <= 1'b0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        gnt_id   <= found_id;
                        gnt_vld  <= 1'b1;
                        hold_cnt <= '0;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        gnt_vld <= 1'b0;
                        state   <= ST_IDLE;
                        ptr     <= gnt_id + 4'd1;
                        // Forced release only: a coincident done or dropped request wins.
                        timeout <= hold_expired & ~done & req[gnt_id];
                    end else if (!hold_expired) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // gnt_vld is registered with async reset, so gnt falls as soon as rst rises.
    dec_4_to_16 u_dec (
        .addr (gnt_id),
        .en   (gnt_vld),
        .dec  (gnt)
    );

    assign state_dbg = state;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Self-checking bench for rr_arbiter_16: directed scenarios with an expected-grant queue.
module tb_rr_arbiter_16;
    import rr_arbiter_16_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0;
    logic        done = 1'b0;
    logic [15:0] gnt;
    logic [3:0]  gnt_id;
    logic        gnt_vld;
    logic        timeout;
    arb_state_e  state_dbg;

    int tests_run = 0;
    int tests_failed = 0;
    logic [3:0] exp_q[$];

    rr_arbiter_16 #(.MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_vld   (gnt_vld),
        .timeout   (timeout),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; req = '0; done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_vld(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (!seen) begin
                @(negedge clk);
                seen = gnt_vld;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 16'hFFFF; done = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (gnt !== 16'h0) begin tests_failed++; $display("FAIL reset_gnt: got %h want 0000", gnt); end
        tests_run++; if (gnt_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_vld: got %b want 0", gnt_vld); end
        tests_run++; if (gnt_id !== 4'd0) begin tests_failed++; $display("FAIL reset_id: got %0d want 0", gnt_id); end
        tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        tests_run++; if (state_dbg !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
        req = '0; done = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (gnt_vld !== 1'b0 || gnt !== 16'h0) begin tests_failed++; $display("FAIL idle_no_req: vld %b gnt %h want 0/0000", gnt_vld, gnt); end
    endtask

    task automatic test_single;
        logic [3:0] e;
        req = 16'h0001;
        @(negedge clk);
        tests_run++; if (gnt !== 16'h0001 || gnt_id !== 4'd0 || gnt_vld !== 1'b1) begin tests_failed++; $display("FAIL single_grant: gnt %h id %0d vld %b want 0001/0/1", gnt, gnt_id, gnt_vld); end
        done = 1'b1;
        @(negedge clk);
        tests_run++; if (gnt !== 16'h0 || timeout !== 1'b0) begin tests_failed++; $display("FAIL single_done: gnt %h timeout %b want 0000/0", gnt, timeout); end
        done = 1'b0; req = '0;
        @(negedge clk);
        tests_run++; if (gnt_vld !== 1'b0) begin tests_failed++; $display("FAIL single_idle: vld %b want 0", gnt_vld); end
        // ptr now 1: requester 1 beats requester 0
        req = 16'h0003; exp_q.push_back(4'd1);
        @(negedge clk);
        e = exp_q.pop_front();
        tests_run++; if (gnt_id !== e || gnt_vld !== 1'b1) begin tests_failed++; $display("FAIL single_ptr: id %0d vld %b want %0d/1", gnt_id, gnt_vld, e); end
        req = '0;
        @(negedge clk);
        tests_run++; if (gnt_vld !== 1'b0 || timeout !== 1'b0) begin tests_failed++; $display("FAIL single_reqdrop: vld %b timeout %b want 0/0", gnt_vld, timeout); end
    endtask

    task automatic test_rotation;
        bit prev; int len, gap, ngr; logic [3:0] e;
        do_reset;
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
        exp_q.push_back(4'd0);
        req = 16'hFFFF; done = 1'b0;
        prev = 1'b0; len = 0; gap = 0; ngr = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (gnt_vld && !prev) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
                tests_run++; if (gnt_id !== e) begin tests_failed++; $display("FAIL rot_id: grant %0d got %0d want %0d", ngr, gnt_id, e); end
                tests_run++; if (gnt !== (16'h1 << e)) begin tests_failed++; $display("FAIL rot_onehot: got %h want id %0d", gnt, e); end
                if (ngr > 0) begin
                    tests_run++; if (gap != 1) begin tests_failed++; $display("FAIL rot_gap: got %0d idle cycles want 1", gap); end
                end
                ngr++; len = 1;
            end else if (gnt_vld) begin
                len++;
            end else if (prev) begin
                tests_run++; if (len != 3) begin tests_failed++; $display("FAIL rot_len: got %0d want 3", len); end
                gap = 1;
            end else begin
                gap++;
            end
            tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL rot_timeout: got %b want 0", timeout); end
            done = gnt_vld && (len == 3);
            prev = gnt_vld;
            if (ngr == 17 && !gnt_vld) break;
        end
        tests_run++; if (ngr != 17) begin tests_failed++; $display("FAIL rot_count: got %0d grants want 17", ngr); end
        req = '0; done = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_wrap;
        bit prev; int ngr; logic [3:0] e;
        do_reset;
        exp_q.push_back(4'd14); exp_q.push_back(4'd15);
        exp_q.push_back(4'd0);  exp_q.push_back(4'd15);
        req = 16'h4000; prev = 1'b0; ngr = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (gnt_vld && !prev) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
                tests_run++; if (gnt_id !== e) begin tests_failed++; $display("FAIL wrap_id: grant %0d got %0d want %0d", ngr, gnt_id, e); end
                ngr++;
                req = 16'h8001;
            end
            done = gnt_vld;
            prev = gnt_vld;
            if (ngr == 4 && !gnt_vld) break;
        end
        tests_run++; if (ngr != 4) begin tests_failed++; $display("FAIL wrap_count: got %0d grants want 4", ngr); end
        req = '0; done = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_timeout;
        bit prev; int len, gap, ngr, npulse; logic [3:0] e;
        do_reset;
        exp_q.push_back(4'd5); exp_q.push_back(4'd5);
        req = 16'h0020; done = 1'b0;
        prev = 1'b0; len = 0; gap = 0; ngr = 0; npulse = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (gnt_vld && !prev) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
                tests_run++; if (gnt_id !== e) begin tests_failed++; $display("FAIL to_id: got %0d want %0d", gnt_id, e); end
                if (ngr > 0) begin
                    tests_run++; if (gap != 1) begin tests_failed++; $display("FAIL to_gap: got %0d want 1", gap); end
                end
                ngr++; len = 1;
            end else if (gnt_vld) begin
                len++;
            end else if (prev) begin
                tests_run++; if (len != 8) begin tests_failed++; $display("FAIL to_len: got %0d want 8", len); end
                tests_run++; if (timeout !== 1'b1) begin tests_failed++; $display("FAIL to_pulse: got %b want 1 in first idle", timeout); end
                gap = 1;
            end else begin
                gap++;
            end
            if (timeout === 1'b1) npulse++;
            prev = gnt_vld;
            if (ngr == 2) break;
        end
        tests_run++; if (ngr != 2 || npulse != 1) begin tests_failed++; $display("FAIL to_count: grants %0d pulses %0d want 2/1", ngr, npulse); end
        req = '0;
        @(negedge clk);
        tests_run++; if (gnt_vld !== 1'b0 || timeout !== 1'b0) begin tests_failed++; $display("FAIL to_reqdrop: vld %b timeout %b want 0/0", gnt_vld, timeout); end
        exp_q.delete();
    endtask

    task automatic test_done_at_timeout;
        bit seen;
        do_reset;
        req = 16'h0020; done = 1'b0;
        wait_vld(5, seen);
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL dto_wait: no grant within 5 cycles"); end
        for (int k = 2; k <= 8; k++) @(negedge clk);
        tests_run++; if (gnt_vld !== 1'b1) begin tests_failed++; $display("FAIL dto_held: vld %b want 1 in 8th cycle", gnt_vld); end
        done = 1'b1;
        @(negedge clk);
        tests_run++; if (gnt_vld !== 1'b0 || timeout !== 1'b0) begin tests_failed++; $display("FAIL dto_release: vld %b timeout %b want 0/0", gnt_vld, timeout); end
        done = 1'b0; req = '0;
        @(negedge clk);
        tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL dto_late: timeout %b want 0", timeout); end
    endtask

    task automatic test_ignore;
        do_reset;
        done = 1'b1; req = '0;
        @(negedge clk);
        tests_run++; if (gnt_vld !== 1'b0) begin tests_failed++; $display("FAIL ign_idle_done: vld %b want 0", gnt_vld); end
        req = 16'h0004;
        @(negedge clk);
        tests_run++; if (gnt_vld !== 1'b1 || gnt_id !== 4'd2) begin tests_failed++; $display("FAIL ign_grant: vld %b id %0d want 1/2", gnt_vld, gnt_id); end
        done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req = 16'($urandom_range(0, 65535)) | 16'h0004;
            @(negedge clk);
            tests_run++; if (gnt_vld !== 1'b1 || gnt_id !== 4'd2) begin tests_failed++; $display("FAIL ign_other: vld %b id %0d want 1/2", gnt_vld, gnt_id); end
        end
        req = '0;
        @(negedge clk);
        tests_run++; if (gnt_vld !== 1'b0) begin tests_failed++; $display("FAIL ign_release: vld %b want 0", gnt_vld); end
    endtask

    task automatic test_async_reset;
        bit seen; logic [3:0] e;
        do_reset;
        req = 16'h0100;
        wait_vld(5, seen);
        tests_run++; if (!seen || gnt !== 16'h0100) begin tests_failed++; $display("FAIL ar_grant: seen %b gnt %h want 1/0100", seen, gnt); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (gnt !== 16'h0 || gnt_vld !== 1'b0) begin tests_failed++; $display("FAIL ar_immediate: gnt %h vld %b want 0000/0", gnt, gnt_vld); end
        tests_run++; if (state_dbg !== ST_IDLE) begin tests_failed++; $display("FAIL ar_state: got %0d want IDLE", state_dbg); end
        @(negedge clk);
        req = 16'h0030; rst = 1'b0;
        exp_q.push_back(4'd4);
        @(negedge clk);
        e = exp_q.pop_front();
        tests_run++; if (gnt_vld !== 1'b1 || gnt_id !== e) begin tests_failed++; $display("FAIL ar_ptr0: vld %b id %0d want 1/%0d", gnt_vld, gnt_id, e); end
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_single;
        test_rotation;
        test_wrap;
        test_timeout;
        test_done_at_timeout;
        test_ignore;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
